// File: rtl/bus_arbiter_if.sv
// Memory-mapped port with waitrequest/readdatavalid handshake, shared by the
// instruction bus, the data bus and the arbitrated memory side.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            read;
  logic            write;
  logic [AW-1:0]   address;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one memory port between ibus (read-only) and dbus; one read in flight.
// Define BUS_ARB_RR_EN for round-robin grants instead of dbus priority with a starvation limit.
module bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.slave  ibus,
  bus_arbiter_if.slave  dbus,
  bus_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;
  typedef enum logic       {OWN_I, OWN_D}     owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t resp_owner_q, resp_owner_d;
  owner_t grant;
  logic   grant_vld;
  logic   grant_read;
  logic   grant_write;
  logic   accept;
  logic   resp_valid;
  logic   rst_q;
  logic   blocked;
  logic   i_req;
  logic   d_req;
  logic   prefer_d;
  logic [AW-1:0]   grant_address;
  logic [DW-1:0]   grant_writedata;
  logic [DW/8-1:0] grant_byteenable;

  assign i_req   = ibus.read;
  assign d_req   = dbus.read | dbus.write;
  // Nothing is issued or forwarded during reset and the cycle right after it.
  assign blocked = rst | rst_q;

  assign ibus.readdata = mem.readdata;
  assign dbus.readdata = mem.readdata;

`ifdef BUS_ARB_RR_EN
  owner_t last_grant_q;

  assign prefer_d = (last_grant_q == OWN_I);

  always_ff @(posedge clk) begin
    if (rst)         last_grant_q <= OWN_I;
    else if (accept) last_grant_q <= grant;
  end
`else
  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;

  assign prefer_d = (starve_q < LIMIT);

  // Counts ibus wait cycles; frozen while a response is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!blocked && state_q != RESP) begin
      if (!ibus.read || (accept && grant == OWN_I)) starve_q <= '0;
      else if (starve_q < LIMIT)                    starve_q <= starve_q + 1'b1;
    end
  end
`endif

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    grant     = OWN_D;
    grant_vld = 1'b0;
    if (!blocked) begin
      case (state_q)
        IDLE: begin
          grant_vld = i_req | d_req;
          grant     = (d_req && (!i_req || prefer_d)) ? OWN_D : OWN_I;
        end
        HOLD: begin
          grant_vld = 1'b1;
          grant     = owner_q;
        end
        default: ;
      endcase
    end
  end

  // A dbus request with both read and write set is a write.
  assign grant_write = (grant == OWN_D) && dbus.write;
  assign grant_read  = (grant == OWN_I) || (dbus.read && !dbus.write);
  assign accept      = grant_vld && !mem.waitrequest;
  assign resp_valid  = !blocked && (state_q == RESP) && mem.readdatavalid;

  assign grant_address    = (grant == OWN_D) ? dbus.address    : ibus.address;
  assign grant_writedata  = dbus.writedata;
  assign grant_byteenable = (grant == OWN_D) ? dbus.byteenable : {(DW/8){1'b1}};

  assign mem.read       = grant_vld && grant_read;
  assign mem.write      = grant_vld && grant_write;
  assign mem.address    = grant_address;
  assign mem.writedata  = grant_writedata;
  assign mem.byteenable = grant_byteenable;

  assign ibus.waitrequest = !(grant_vld && grant == OWN_I) || mem.waitrequest;
  assign dbus.waitrequest = !(grant_vld && grant == OWN_D) || mem.waitrequest;

  assign ibus.readdatavalid = resp_valid && (resp_owner_q == OWN_I);
  assign dbus.readdatavalid = resp_valid && (resp_owner_q == OWN_D);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    resp_owner_d = resp_owner_q;
    if (blocked) begin
      state_d = IDLE;
    end else if (grant_vld) begin
      if (!mem.waitrequest) begin
        state_d      = grant_read ? RESP : IDLE;
        resp_owner_d = grant;
      end else begin
        state_d = HOLD;
        owner_d = grant;
      end
    end else if (resp_valid) begin
      state_d = IDLE;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      resp_owner_q <= OWN_I;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      resp_owner_q <= resp_owner_d;
    end
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares a single memory port between the instruction bus (ibus, read-only) and the data bus (dbus, read/write).
- Sits between IF/LSU and the memory.
- Uses waitrequest/readdatavalid handshakes; at most one read is outstanding at a time.
- Its dbus_waitrequest is the source of the LSU busy condition that stalls the pipeline, so the grant policy directly shapes stall behaviour.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byteenable width is DW/8.
- STARVE_LIMIT, 4, legal range 1..15. Consecutive cycles ibus may wait while dbus is preferred.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ibus_read  in  1  ibus read request
- ibus_address  in  AW  ibus address
- ibus_waitrequest  out  1  request not accepted this cycle
- ibus_readdata  out  DW  read data
- ibus_readdatavalid  out  1  read data valid
- dbus_read  in  1  dbus read request
- dbus_write  in  1  dbus write request
- dbus_address  in  AW  dbus address
- dbus_writedata  in  DW  write data
- dbus_byteenable  in  DW/8  byte enables
- dbus_waitrequest  out  1  request not accepted this cycle
- dbus_readdata  out  DW  read data
- dbus_readdatavalid  out  1  read data valid
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- mem_address  out  AW  memory address
- mem_writedata  out  DW  memory write data
- mem_byteenable  out  DW/8  memory byte enables; all ones for ibus
- mem_waitrequest  in  1  memory not accepting
- mem_readdata  in  DW  memory read data
- mem_readdatavalid  in  1  memory read data valid

Behaviour:
- States: IDLE, HOLD, RESP. Registers: state, owner (I/D), resp_owner (I/D), starve_cnt (width clog2(STARVE_LIMIT+1), saturating).
- Reset:
  - state=IDLE, starve_cnt=0.
  - mem_read, mem_write, ibus_readdatavalid and dbus_readdatavalid are 0 while in reset and the cycle after.
- Requester rule: a requester holds all request signals stable while its waitrequest=1.
- A dbus request is dbus_read|dbus_write. If both are set, the access is treated as a write.
- IDLE:
  - Selection is combinational. dbus wins unless starve_cnt>=STARVE_LIMIT, in which case ibus wins.
  - The selected request drives mem_* in the same cycle; zero added latency.
  - Selected waitrequest = mem_waitrequest. Non-selected waitrequest=1.
  - Accepted (mem_waitrequest=0): write -> stay IDLE; read -> RESP with resp_owner=selected.
  - Not accepted: owner=selected, -> HOLD.
- HOLD:
  - mem_* driven from owner only; the grant cannot switch. Owner waitrequest = mem_waitrequest; the other = 1.
  - On accept: write -> IDLE, read -> RESP.
- RESP:
  - mem_read=mem_write=0; both waitrequest=1.
  - On mem_readdatavalid: route valid to resp_owner only, -> IDLE.
  - The next request is not issued in the same cycle as readdatavalid.
- ibus_readdata and dbus_readdata = mem_readdata, combinationally, always.
- mem_readdatavalid outside RESP is dropped; no valid is forwarded.
- starve_cnt:
  - +1 (saturating) each cycle ibus_read=1 and ibus not accepted.
  - Cleared on the cycle ibus is accepted, and when ibus_read=0.
  - Frozen in RESP.
- Reset mid-operation (HOLD/RESP): go to IDLE. The outstanding memory response is discarded per the rule above.
- mem_address, mem_writedata and mem_byteenable are don't-care when mem_read=mem_write=0.

Optional Feature:
- Macro BUS_ARB_RR_EN.
- Defined:
  - starve_cnt and STARVE_LIMIT are unused.
  - A last_grant register (reset = I) replaces them.
  - On contention in IDLE, the requester not equal to last_grant wins. last_grant updates on every accept.
- Undefined: fixed dbus priority with the starvation limit, as described above.

Test Plan:
1. ibus_read only, addr 0x100, mem zero-wait, readdatavalid 2 cycles after accept -> ibus_waitrequest=0 at cycle 0; ibus_readdatavalid=1 at cycle 2 with data 0xDEADBEEF; dbus_readdatavalid stays 0.
2. ibus_read and dbus_read asserted together, starve_cnt=0 -> dbus accepted first. ibus is accepted only after dbus readdatavalid and a return to IDLE.
3. Back-to-back zero-wait dbus writes for 10 cycles while ibus_read is held, STARVE_LIMIT=4 -> ibus accepted in cycle 4; starve_cnt returns to 0 the cycle after.
4. dbus write to 0x2000 with mem_waitrequest=1 for 3 cycles, ibus_read arriving in cycle 1 -> mem_address stays 0x2000 and mem_write=1 throughout; ibus_waitrequest=1; ibus accepted in the cycle after the write accepts.
5. rst asserted while in RESP, then mem_readdatavalid=1 one cycle after rst deasserts -> state IDLE; both readdatavalid outputs stay 0; mem_read=0.
6. With BUS_ARB_RR_EN: continuous ibus and dbus reads, zero-wait, 1-cycle response -> grants alternate D, I, D, I after reset (last_grant=I, so D first).
